// File: rtl/mem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states, port indices, request bundle.
package mem_arb_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } arb_state_t;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_DBG  = 1'b1;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  mask;
  } mem_req_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way priority picker: sole requester wins, otherwise the port named by prio.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       prio,
  output logic [1:0] gnt,
  output logic       win
);

  always_comb begin
    win = req[1] & (~req[0] | prio);
    gnt = {req[1] & win, req[0] & ~win};
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one synchronous-read data memory between core (port 0)
// and debug/loader (port 1); stores finish in the grant cycle, loads return one cycle later.
module dmem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MAX_LOCK = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  input  logic [2:0]  c_mask,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [2:0]  d_mask,
  input  logic        d_lock,
  output logic        c_gnt,
  output logic        d_gnt,
  output logic        c_rvalid,
  output logic        d_rvalid,
  output logic [31:0] rdata,
  output logic        c_stall,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_mask,
  output logic        mem_rd_en,
  output logic        mem_wr_en,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(MAX_LOCK + 1);
  localparam logic [CW-1:0] LOCK_MAX = CW'(MAX_LOCK);

  arb_state_t    state_q, state_d;
  logic          prio_q, prio_d;
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;
  logic          out_port_q, out_port_d;
  logic [31:0]   rdata_q, rdata_d;

  logic [1:0] req_vec;
  logic [1:0] gnt;
  logic       win;
  logic       granted;
  mem_req_t   c_bus, d_bus, sel;

  // Grants are suppressed while reset is high so the memory sees nothing during reset.
  assign req_vec = {d_req, c_req} & {2{(state_q == IDLE) & ~reset}};
  assign c_bus   = '{we: c_we, addr: c_addr, wdata: c_wdata, mask: c_mask};
  assign d_bus   = '{we: d_we, addr: d_addr, wdata: d_wdata, mask: d_mask};

  rr_pick2 u_pick (
    .req  (req_vec),
    .prio (prio_q),
    .gnt  (gnt),
    .win  (win)
  );

  always_comb begin
    granted   = |gnt;
    sel       = win ? d_bus : c_bus;
    c_gnt     = gnt[PORT_CORE];
    d_gnt     = gnt[PORT_DBG];
    mem_addr  = granted ? sel.addr  : 32'h0;
    mem_wdata = granted ? sel.wdata : 32'h0;
    mem_mask  = granted ? sel.mask  : 3'b000;
    mem_wr_en = granted & sel.we;
    mem_rd_en = granted & ~sel.we;

    c_rvalid  = (state_q == RD_WAIT) & (out_port_q == PORT_CORE);
    d_rvalid  = (state_q == RD_WAIT) & (out_port_q == PORT_DBG);
    rdata     = (c_rvalid | d_rvalid) ? mem_rdata : rdata_q;
    c_stall   = ~reset & c_req & ~(c_gnt & c_we) & ~c_rvalid;

    state_d    = state_q;
    out_port_d = out_port_q;
    rdata_d    = rdata_q;
    case (state_q)
      IDLE: begin
        if (mem_rd_en) begin
          state_d    = RD_WAIT;
          out_port_d = win;
        end
      end
      RD_WAIT: begin
        state_d = IDLE;
        rdata_d = mem_rdata;
      end
      default: state_d = IDLE;
    endcase

    lock_cnt_d = lock_cnt_q;
    if (!d_lock || c_gnt) begin
      lock_cnt_d = '0;
    end else if (d_gnt && lock_cnt_q != LOCK_MAX) begin
      lock_cnt_d = lock_cnt_q + CW'(1);
    end

    // Port 1 keeps priority under lock until its run reaches MAX_LOCK, then yields once.
    prio_d = prio_q;
    if (granted) begin
      prio_d = ~win;
      if (d_gnt && d_lock && lock_cnt_d != LOCK_MAX) prio_d = PORT_DBG;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      prio_q     <= PORT_CORE;
      lock_cnt_q <= '0;
      out_port_q <= PORT_CORE;
      rdata_q    <= 32'h0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      lock_cnt_q <= lock_cnt_d;
      out_port_q <= out_port_d;
      rdata_q    <= rdata_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a rule-level model is checked every cycle, plus hand-computed literals.
module tb_dmem_arbiter;

  localparam int MAX_LOCK = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        c_req, c_we, d_req, d_we, d_lock;
  logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
  logic [2:0]  c_mask, d_mask;
  logic        c_gnt, d_gnt, c_rvalid, d_rvalid, c_stall;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_mask;
  logic        mem_rd_en, mem_wr_en;

  always #5 clk = ~clk;

  dmem_arbiter #(.MAX_LOCK(MAX_LOCK)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_mask(c_mask),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_mask(d_mask),
    .d_lock(d_lock),
    .c_gnt(c_gnt), .d_gnt(d_gnt), .c_rvalid(c_rvalid), .d_rvalid(d_rvalid),
    .rdata(rdata), .c_stall(c_stall),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_mask(mem_mask),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_rdata(mem_rdata)
  );

  // Memory with one-cycle synchronous read
  logic [31:0] tb_mem [256];
  always @(posedge clk) begin
    if (mem_wr_en) tb_mem[mem_addr[9:2]] <= mem_wdata;
    if (mem_rd_en) mem_rdata <= tb_mem[mem_addr[9:2]];
  end

  // Rule-level model: who has precedence, length of the locked port-1 run, pending load
  int          m_prio, m_run, m_wait;
  logic [31:0] m_rdata, m_load_val;
  logic [31:0] sh [256];

  function automatic int winner();
    if (reset || m_wait >= 0) return -1;
    if (c_req && d_req) return m_prio;
    if (c_req) return 0;
    if (d_req) return 1;
    return -1;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_prio  <= 0;
      m_run   <= 0;
      m_wait  <= -1;
      m_rdata <= 32'h0;
    end else if (m_wait >= 0) begin
      m_wait  <= -1;
      m_rdata <= m_load_val;
      if (!d_lock) m_run <= 0;
    end else if (winner() == 0) begin
      m_run  <= 0;
      m_prio <= 1;
      if (c_we) sh[c_addr[9:2]] <= c_wdata;
      else begin
        m_wait     <= 0;
        m_load_val <= sh[c_addr[9:2]];
      end
    end else if (winner() == 1) begin
      if (d_lock) begin
        m_run  <= (m_run < MAX_LOCK) ? m_run + 1 : MAX_LOCK;
        m_prio <= (m_run + 1 < MAX_LOCK) ? 1 : 0;
      end else begin
        m_run  <= 0;
        m_prio <= 0;
      end
      if (d_we) sh[d_addr[9:2]] <= d_wdata;
      else begin
        m_wait     <= 1;
        m_load_val <= sh[d_addr[9:2]];
      end
    end else if (!d_lock) begin
      m_run <= 0;
    end
  end

  function automatic logic [105:0] exp_obs();
    logic cg, dg, cr, dr, st, rd, wr;
    logic [2:0]  mk;
    logic [31:0] a, wd, rv;
    int w;
    if (reset) return '0;
    cg = 1'b0; dg = 1'b0; rd = 1'b0; wr = 1'b0;
    mk = 3'b000; a = 32'h0; wd = 32'h0;
    cr = (m_wait == 0);
    dr = (m_wait == 1);
    rv = (cr || dr) ? m_load_val : m_rdata;
    w  = winner();
    if (w == 0) begin
      cg = 1'b1; wr = c_we; rd = ~c_we; mk = c_mask; a = c_addr; wd = c_wdata;
    end else if (w == 1) begin
      dg = 1'b1; wr = d_we; rd = ~d_we; mk = d_mask; a = d_addr; wd = d_wdata;
    end
    st = c_req & ~(cg & c_we) & ~cr;
    return {cg, dg, cr, dr, st, rd, wr, mk, a, wd, rv};
  endfunction

  logic [105:0] act_v;
  assign act_v = {c_gnt, d_gnt, c_rvalid, d_rvalid, c_stall, mem_rd_en, mem_wr_en,
                  mem_mask, mem_addr, mem_wdata, rdata};

  // Literal expectations set by the stimulus for the current cycle
  logic        lit_on = 1'b0, lit_rd_chk = 1'b0, lit_addr_chk = 1'b0;
  logic [6:0]  lit_mask = '0, lit_obs = '0;
  logic [31:0] lit_rdata = '0, lit_addr = '0;
  string       lit_name = "";

  int n_chk = 0;
  int n_fail = 0;

  function automatic logic lit_bad();
    return lit_on && (((act_v[105:99] & lit_mask) !== (lit_obs & lit_mask)) ||
                      (lit_rd_chk && rdata !== lit_rdata) ||
                      (lit_addr_chk && mem_addr !== lit_addr));
  endfunction

  always @(negedge clk) begin
    n_chk  <= n_chk + 1 + int'(lit_on);
    n_fail <= n_fail + int'(act_v !== exp_obs()) + int'(lit_bad());
    if (act_v !== exp_obs())
      $display("FAIL model t=%0t: got %h want %h", $time, act_v, exp_obs());
    if (lit_bad())
      $display("FAIL %s: flags %b want %b (mask %b) rdata %h want %h addr %h want %h",
               lit_name, act_v[105:99], lit_obs, lit_mask, rdata, lit_rdata, mem_addr, lit_addr);
  end

  task automatic drive(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                       input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd,
                       input logic dl);
    c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd; c_mask = 3'b010;
    d_req = dr; d_we = dw; d_addr = da; d_wdata = dd; d_mask = 3'b010;
    d_lock = dl;
  endtask

  task automatic lit(input string name, input logic [6:0] mask, input logic [6:0] obs);
    lit_on = 1'b1; lit_name = name; lit_mask = mask; lit_obs = obs;
  endtask

  task automatic lit_rd(input logic [31:0] v);
    lit_rd_chk = 1'b1; lit_rdata = v;
  endtask

  task automatic lit_ad(input logic [31:0] v);
    lit_addr_chk = 1'b1; lit_addr = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    lit_on = 1'b0; lit_rd_chk = 1'b0; lit_addr_chk = 1'b0;
  endtask

  // flags: {c_gnt, d_gnt, c_rvalid, d_rvalid, c_stall, mem_rd_en, mem_wr_en}
  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    lit("reset_state", 7'h7F, 7'b0000000); lit_rd(32'h0); lit_ad(32'h0);
    step();
    reset = 1'b0;

    drive(1, 1, 32'h100, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    lit("core_store", 7'h7F, 7'b1000001); lit_ad(32'h100);
    step();

    drive(1, 0, 32'h100, 0, 0, 0, 0, 0, 0);
    lit("core_load_grant", 7'h7F, 7'b1000110); lit_ad(32'h100);
    step();
    lit("core_load_rvalid", 7'h7F, 7'b0010000); lit_rd(32'hDEADBEEF);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    lit("rdata_hold", 7'h7F, 7'b0000000); lit_rd(32'hDEADBEEF);
    step();

    reset = 1'b1;
    step();
    reset = 1'b0;
    drive(1, 1, 32'h200, 32'h11111111, 1, 1, 32'h204, 32'h22222222, 0);
    for (int i = 0; i < 4; i++) begin
      lit("alternate", 7'b1100000, (i % 2 == 0) ? 7'b1000000 : 7'b0100000);
      step();
    end

    drive(1, 1, 32'h200, 32'h11111111, 0, 0, 0, 0, 0);
    lit("prio_setup", 7'b1100000, 7'b1000000);
    step();
    drive(1, 1, 32'h200, 32'h11111111, 1, 1, 32'h204, 32'h22222222, 1);
    for (int i = 0; i < 10; i++) begin
      lit("lock_run", 7'h7F, (i == 8) ? 7'b1000001 : 7'b0100101);
      step();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();

    drive(0, 0, 0, 0, 1, 0, 32'h100, 0, 1);
    lit("dbg_load_grant", 7'h7F, 7'b0100010);
    step();
    reset = 1'b1;
    lit("reset_in_wait", 7'h7F, 7'b0000000); lit_ad(32'h0); lit_rd(32'h0);
    step();
    lit("reset_held", 7'h7F, 7'b0000000); lit_ad(32'h0);
    step();
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      lit("no_rvalid_after_reset", 7'h7F, 7'b0000000); lit_rd(32'h0);
      step();
    end

    drive(1, 0, 32'h100, 0, 1, 0, 32'h204, 0, 0);
    lit("dual_load_c_gnt", 7'h7F, 7'b1000110); lit_ad(32'h100);
    step();
    lit("dual_load_c_rvalid", 7'h7F, 7'b0010000); lit_rd(32'hDEADBEEF);
    step();
    drive(0, 0, 0, 0, 1, 0, 32'h204, 0, 0);
    lit("dual_load_d_gnt", 7'h7F, 7'b0100010); lit_ad(32'h204);
    step();
    lit("dual_load_d_rvalid", 7'h7F, 7'b0001000); lit_rd(32'h22222222);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    lit("final_hold", 7'h7F, 7'b0000000); lit_rd(32'h22222222);
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single data memory between two requesters: port 0 is the core's load/store path and port 1 is a debug/loader master. The block sits between the core's ALU-address / store-data / mask signals and the data memory's address, write-data, mask, read-enable and write-enable inputs. It applies round-robin arbitration, sequences the memory's one-cycle synchronous read, and produces the core stall. Port 1 can take a bounded lock for atomic multi-access sequences.

## Interface
- `MAX_LOCK`, default 8: maximum consecutive port-1 grants under lock before port 0 is forced one grant.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `c_req`, `d_req` in 1: access request, port 0 / port 1.
- `c_we`, `d_we` in 1: 1 = store, 0 = load.
- `c_addr`, `d_addr` in 32: byte address.
- `c_wdata`, `d_wdata` in 32: store data.
- `c_mask`, `d_mask` in 3: access-size/sign code, passed to memory unchanged.
- `d_lock` in 1: port 1 requests priority retention.
- `c_gnt`, `d_gnt` out 1: access presented to memory this cycle.
- `c_rvalid`, `d_rvalid` out 1: load data valid this cycle.
- `rdata` out 32: load data, shared by both ports and qualified by `*_rvalid`.
- `c_stall` out 1: core must hold PC and state.
- `mem_addr` out 32, `mem_wdata` out 32, `mem_mask` out 3, `mem_rd_en` out 1, `mem_wr_en` out 1: memory side.
- `mem_rdata` in 32: memory read data, valid one cycle after `mem_rd_en`.

## Operation
- FSM has two states.
  - `IDLE`: grants are possible.
  - `RD_WAIT`: a load is outstanding. No grant is issued and all requests are ignored.
- Winner selection happens in `IDLE` only.
  - With one requester, that requester wins.
  - With both requesting, the port named by the `prio` register (0 or 1) wins.
- Grant is combinational in the same cycle. The winner's addr, wdata and mask drive `mem_*`, and `mem_wr_en = we` and `mem_rd_en = ~we`.
  - Non-winner's `gnt` is 0.
  - When nobody is granted, `mem_*` are all 0.
- Store: completes in the grant cycle and the FSM stays in `IDLE`.
- Load: the FSM records the granting port and moves to `RD_WAIT`. In the next cycle, that port's `rvalid` = 1, `rdata = mem_rdata`, and the FSM returns to `IDLE`.
- `prio` update on each grant: `prio` is set to the non-winning port. Exception: when port 1 wins with `d_lock` = 1 and `lock_cnt` < `MAX_LOCK`, `prio` stays 1.
- `lock_cnt`:
  - Increments on each port-1 grant taken with `d_lock` = 1.
  - Clears on any port-0 grant, or on a cycle with `d_lock` = 0.
  - At `lock_cnt` == `MAX_LOCK`, `prio` is forced to 0.
- Requesters hold `req` and their attributes stable until `gnt`. A load requester's `req` in its `rvalid` cycle is not re-granted, because the FSM is in `RD_WAIT`.
- `c_stall = c_req & ~(c_gnt & c_we) & ~c_rvalid`.
- `rdata` holds its last value when no `rvalid` is asserted.

## Timing
- Store latency: 0 cycles (grant cycle).
- Load latency: 1 cycle from grant to `rvalid`.
- Maximum throughput: 1 store/cycle, or 1 load per 2 cycles.
- Reset values: state `IDLE`, `prio` 0, `lock_cnt` 0, `rdata` 0. All `gnt`, `rvalid`, `stall`-driving registers and `mem_*` are 0.
- Reset asserted during `RD_WAIT` aborts the load: no `rvalid` is produced after reset releases.
- Simultaneous `c_req`/`d_req` on reset release: port 0 wins.
- Starvation bound: port 0 waits at most `MAX_LOCK` port-1 grants, plus 1 outstanding load, before it is granted.
- `lock_cnt` saturates at `MAX_LOCK` and never wraps.

## Structure
- Package `mem_arb_pkg` contains:
  - FSM state enum `arb_state_t` {`IDLE`, `RD_WAIT`}.
  - Port index constants `PORT_CORE` = 0, `PORT_DBG` = 1.
  - `mem_req_t` struct {we, addr, wdata, mask}.
- Sub-module `rr_pick2` is combinational. Inputs are two request bits and `prio`. Outputs are a one-hot grant and the winner index.
- The FSM, `prio`, `lock_cnt`, outstanding-port register, `rdata` register and `mem_*` muxing live in `dmem_arbiter`.

## Test plan
- Core only, `c_we`=1, `c_addr`=0x100, `c_wdata`=0xDEADBEEF, `c_mask`=3'b010 → same cycle `c_gnt`=1, `mem_wr_en`=1, `mem_addr`=0x100, `c_stall`=0.
- Core load from 0x100 after the store above → grant cycle `c_stall`=1, `mem_rd_en`=1. Next cycle `c_rvalid`=1, `rdata`=0xDEADBEEF, `c_stall`=0. No second grant in that cycle.
- Both requesting stores every cycle, `d_lock`=0 → grants alternate c, d, c, d, starting with c after reset.
- `d_lock`=1 with both requesting stores and `MAX_LOCK`=8, starting with `prio`=1 → 8 consecutive `d_gnt`, then 1 `c_gnt`, then `d_gnt` resumes.
- Port 1 load granted, `reset` pulsed in `RD_WAIT` → `d_rvalid` is never asserted, and all outputs are 0 while `reset` is high.
- Simultaneous loads from both ports → c is granted, then a `RD_WAIT` cycle with `c_rvalid`=1, then d is granted, then `d_rvalid`=1. Total 4 cycles.
